// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 16-bit pipelined core. Other files pull these in
// with "import cpu_pkg::*".
//   - opcode constants, including OPC_HLT
//   - the NOP encoding and the reset vector
//   - the fetch-stage state enum
//   - cla_add16: the core's 16-bit carry-lookahead adder, written as a function
package cpu_pkg;

    // Opcode field is instr[15:12]
    localparam logic [3:0] OPC_ADD = 4'h0;
    localparam logic [3:0] OPC_SUB = 4'h1;
    localparam logic [3:0] OPC_AND = 4'h2;
    localparam logic [3:0] OPC_OR  = 4'h3;
    localparam logic [3:0] OPC_LDI = 4'h4;
    localparam logic [3:0] OPC_LD  = 4'h8;
    localparam logic [3:0] OPC_ST  = 4'h9;
    localparam logic [3:0] OPC_BEQ = 4'hC;
    localparam logic [3:0] OPC_JMP = 4'hD;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam logic [15:0] NOP_ENCODING = 16'h0000;
    localparam logic [15:0] RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Two-level carry lookahead: four 4-bit groups. Group generate/propagate
    // terms produce the group carries directly; the carries inside each group
    // are then expanded from the group carry-in. Carry-out is discarded, so
    // the result wraps modulo 2^16.
    function automatic logic [15:0] cla_add16(input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  pg;
        logic [3:0]  gc;
        int          base;
        g = a & b;
        p = a ^ b;
        for (int grp = 0; grp < 4; grp++) begin
            base    = grp * 4;
            gg[grp] = g[base+3]
                    | (p[base+3] & g[base+2])
                    | (p[base+3] & p[base+2] & g[base+1])
                    | (p[base+3] & p[base+2] & p[base+1] & g[base]);
            pg[grp] = &p[base +: 4];
        end
        gc[0] = 1'b0;
        gc[1] = gg[0] | (pg[0] & gc[0]);
        gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & gc[0]);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & gc[0]);
        for (int grp = 0; grp < 4; grp++) begin
            base      = grp * 4;
            c[base]   = gc[grp];
            c[base+1] = g[base] | (p[base] & gc[grp]);
            c[base+2] = g[base+1] | (p[base+1] & g[base])
                      | (p[base+1] & p[base] & gc[grp]);
            c[base+3] = g[base+2] | (p[base+2] & g[base+1])
                      | (p[base+2] & p[base+1] & g[base])
                      | (p[base+2] & p[base+1] & p[base] & gc[grp]);
        end
        return p ^ c;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg
// The 33-bit IF/ID pipeline register: {instr[15:0], pc_plus2[15:0], valid}.
// Ports:
//   clk, rst         - core clock; synchronous active-high reset
//   squash           - load a bubble (NOP_INSTR, valid 0); beats hold
//   hold             - keep current contents
//   load             - capture instr_in / pc_plus2_in as a valid instruction
//   instr_in         - fetched instruction word
//   pc_plus2_in      - PC+2 of that instruction
//   ifid_instr, ifid_pc_plus2, ifid_valid - registered outputs
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        squash,
    input  logic        hold,
    input  logic        load,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus2_in,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid
);

    // Squash has priority over hold so that a flush still clears a stalled
    // stage. With no control asserted the register simply holds.
    always_ff @(posedge clk) begin
        if (rst || squash) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus2 <= 16'h0000;
            ifid_valid    <= 1'b0;
        end else if (load && !hold) begin
            ifid_instr    <= instr_in;
            ifid_pc_plus2 <= pc_plus2_in;
            ifid_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage: holds the architectural PC, drives the instruction
// memory request and owns the IF/ID register (ifid_reg).
// Ports:
//   clk, rst       - core clock; synchronous active-high reset
//   pc_next        - next PC from PC control (already equals PC on halt/stall)
//   branch_taken   - flush: redirect to pc_next and squash IF/ID
//   stall          - hazard stall: hold PC, IF/ID and state
//   imem_data      - instruction word at imem_addr
//   imem_ready     - imem_data valid this cycle
//   imem_addr      - fetch address (= pc_curr)
//   imem_req       - fetch request, low only while HALTED
//   pc_curr        - current PC, to PC control
//   halt_fetched   - combinational: the word arriving now is HLT
//   fetch_busy     - high in WAIT
//   ifid_instr, ifid_pc_plus2, ifid_valid - IF/ID register outputs
// Optional (macro FETCH_PERF_CNT_EN): perf_fetched, perf_wait_cycles,
//   perf_flushes - 32-bit wrapping event counters cleared by rst.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_VECTOR,
    parameter logic [15:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_next,
    input  logic        branch_taken,
    input  logic        stall,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    output logic [15:0] pc_curr,
    output logic        halt_fetched,
    output logic        fetch_busy,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_wait_cycles,
    output logic [31:0] perf_flushes
`endif
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [15:0]  pc;
    logic [15:0]  pc_nxt;
    logic [15:0]  pc_plus2;
    logic         active;
    logic         advance;
    logic         word_is_hlt;
    logic         ifid_squash;

    assign active      = (state != HALTED);
    assign word_is_hlt = (imem_data[15:12] == OPC_HLT);
    assign advance     = active & imem_ready & ~stall & ~branch_taken;
    assign pc_plus2    = cla_add16(pc, 16'h0002);

    assign imem_req     = active;
    assign imem_addr    = pc;
    assign pc_curr      = pc;
    assign fetch_busy   = (state == WAIT);
    assign halt_fetched = active & imem_ready & word_is_hlt;

    // A bubble goes into IF/ID on a flush, and on any unstalled cycle that
    // does not accept a word (memory not ready, or halted).
    assign ifid_squash = branch_taken | (~stall & ~advance);

    // State and PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next state / next PC. A flush always returns to RUN, which is also the
    // only way out of HALTED short of reset; any word the memory was about to
    // deliver for the old PC is simply not accepted.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (branch_taken) begin
            state_nxt = RUN;
            pc_nxt    = pc_next;
        end else if (stall) begin
            state_nxt = state;
            pc_nxt    = pc;
        end else if (advance) begin
            pc_nxt    = pc_next;
            state_nxt = word_is_hlt ? HALTED : RUN;
        end else if (active) begin
            state_nxt = WAIT;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk           (clk),
        .rst           (rst),
        .squash        (ifid_squash),
        .hold          (stall),
        .load          (advance),
        .instr_in      (imem_data),
        .pc_plus2_in   (pc_plus2),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    // Event counters; they observe the fetch stage and never influence it.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched     <= 32'd0;
            perf_wait_cycles <= 32'd0;
            perf_flushes     <= 32'd0;
        end else begin
            if (advance) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (state == WAIT) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
            if (branch_taken) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// compared cycle by cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] pc_next;
    logic        branch_taken;
    logic        stall;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] pc_curr;
    logic        halt_fetched;
    logic        fetch_busy;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;

    int passCount;
    int checkCount;

    // Behavioural model of the architectural fetch state
    logic [15:0] mPc;
    logic [15:0] mInstr;
    logic [15:0] mPcPlus2;
    logic        mValid;
    logic        mHalted;
    logic        mWaiting;
    bit          mKnown;

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_next       (pc_next),
        .branch_taken  (branch_taken),
        .stall         (stall),
        .imem_data     (imem_data),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .pc_curr       (pc_curr),
        .halt_fetched  (halt_fetched),
        .fetch_busy    (fetch_busy),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // One clock cycle. Inputs are driven just after a rising edge, the
    // combinational outputs are checked mid-cycle, then the model advances
    // at the edge and the registered outputs are checked just after it.
    // pc_next plays the role of PC control: target on a flush, PC+2 when a
    // non-HLT word is accepted, otherwise the current PC.
    task automatic applyStimulus(input bit r, input bit br, input logic [15:0] tgt,
                                 input bit st, input bit rdy, input logic [15:0] data);
        logic        takes;
        logic        isHlt;
        logic [15:0] pcn;
        isHlt = (data[15:12] == 4'hF);
        takes = !mHalted && rdy && !st && !br;
        if (br)                 pcn = tgt;
        else if (takes && !isHlt) pcn = 16'((32'(mPc) + 32'd2) % 32'h10000);
        else                    pcn = mPc;
        rst          = r;
        branch_taken = br;
        stall        = st;
        imem_ready   = rdy;
        imem_data    = data;
        pc_next      = pcn;
        #4;
        if (mKnown) begin
            checkOutput("halt_fetched", 32'(halt_fetched),
                        32'(!mHalted && rdy && isHlt));
            checkOutput("imem_req", 32'(imem_req), 32'(!mHalted));
            checkOutput("imem_addr", 32'(imem_addr), 32'(mPc));
        end
        @(posedge clk);
        #1;
        if (r) begin
            mPc = 16'h0000; mInstr = 16'h0000; mPcPlus2 = 16'h0000;
            mValid = 1'b0; mHalted = 1'b0; mWaiting = 1'b0;
        end else if (br) begin
            mPc = tgt; mInstr = 16'h0000; mValid = 1'b0;
            mHalted = 1'b0; mWaiting = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (takes) begin
            mPcPlus2 = 16'((32'(mPc) + 32'd2) % 32'h10000);
            mPc      = pcn;
            mInstr   = data;
            mValid   = 1'b1;
            mHalted  = isHlt;
            mWaiting = 1'b0;
        end else begin
            mInstr = 16'h0000;
            mValid = 1'b0;
            if (!mHalted) mWaiting = 1'b1;
        end
        mKnown = 1'b1;
        checkOutput("pc_curr", 32'(pc_curr), 32'(mPc));
        checkOutput("ifid_valid", 32'(ifid_valid), 32'(mValid));
        checkOutput("ifid_instr", 32'(ifid_instr), 32'(mInstr));
        if (mValid) checkOutput("ifid_pc_plus2", 32'(ifid_pc_plus2), 32'(mPcPlus2));
        checkOutput("fetch_busy", 32'(fetch_busy), 32'(mWaiting));
        checkOutput("imem_req_after", 32'(imem_req), 32'(!mHalted));
    endtask

    // Non-HLT word derived from the address, so refetches see the same data
    function automatic logic [15:0] memWord(input logic [15:0] addr);
        logic [15:0] w;
        w = (addr * 16'h9E37) ^ 16'h5A5A;
        if (w[15:12] == 4'hF) w[15:12] = 4'h1;
        return w;
    endfunction

    initial begin
        passCount = 0;
        checkCount = 0;
        mKnown = 1'b0;
        mPc = 16'h0000; mInstr = 16'h0000; mPcPlus2 = 16'h0000;
        mValid = 1'b0; mHalted = 1'b0; mWaiting = 1'b0;
        rst = 1'b1; branch_taken = 1'b0; stall = 1'b0;
        imem_ready = 1'b0; imem_data = 16'h0000; pc_next = 16'h0000;
        @(posedge clk);
        #1;

        // Reset, then straight-line fetch 0000, 0002, 0004
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 16'h0, 0, 1, memWord(mPc));
        checkOutput("seq_pc_0004", 32'(pc_curr), 32'h0004);

        // Memory not ready for 3 cycles, then resume
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, memWord(mPc));
        applyStimulus(0, 0, 16'h0, 0, 1, memWord(mPc));

        // Two stall cycles with a ready word, then resume
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 16'h0, 1, 1, memWord(mPc));
        applyStimulus(0, 0, 16'h0, 0, 1, memWord(mPc));

        // Flush to 0040 while waiting; flush wins over a simultaneous stall
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(0, 1, 16'h0040, 1, 1, memWord(mPc));
        checkOutput("branch_pc_0040", 32'(pc_curr), 32'h0040);
        applyStimulus(0, 0, 16'h0, 0, 1, memWord(mPc));

        // HLT at 0010, idle while halted, then flush to 0020
        applyStimulus(0, 1, 16'h0010, 0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, 16'hF000);
        checkOutput("hlt_in_ifid", 32'(ifid_instr), 32'hF000);
        applyStimulus(0, 0, 16'h0, 1, 1, memWord(mPc));
        applyStimulus(0, 0, 16'h0, 0, 1, 16'hF000);
        applyStimulus(0, 1, 16'h0020, 0, 1, memWord(mPc));
        applyStimulus(0, 0, 16'h0, 0, 1, memWord(mPc));

        // PC+2 wraps at FFFE
        applyStimulus(0, 1, 16'hFFFE, 0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, memWord(mPc));
        checkOutput("wrap_pc_plus2", 32'(ifid_pc_plus2), 32'h0000);

        // Reset out of HALTED and out of WAIT
        applyStimulus(0, 0, 16'h0, 0, 1, 16'hF123);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(1, 0, 16'h0, 0, 1, memWord(mPc));

        // Randomized traffic; opcodes are random, so HLT shows up naturally
        for (int i = 0; i < 600; i++) begin
            bit          r;
            bit          br;
            bit          st;
            bit          rdy;
            logic [15:0] tgt;
            r   = ($urandom % 80) == 0;
            br  = ($urandom % 10) == 0;
            st  = ($urandom % 6) == 0;
            rdy = ($urandom % 4) != 0;
            tgt = 16'($urandom) & 16'hFFFE;
            applyStimulus(r, br, tgt, st, rdy, 16'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipelined core. It holds the architectural PC and drives the instruction-memory request. It also owns the IF/ID pipeline register, and it feeds the current PC and a halt indication to the PC control logic. Each cycle it takes back the computed next PC and the branch-taken flush from that logic.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0000, encoding inserted into IF/ID on flush or bubble

Ports:
- clk  in  1  single core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_next  in  16  next PC from PC control (already holds PC on halt/stall)
- branch_taken  in  1  flush request; redirect to pc_next, squash IF/ID
- stall  in  1  hazard-unit stall; hold PC and IF/ID
- imem_data  in  16  instruction word at imem_addr
- imem_ready  in  1  imem_data valid this cycle
- imem_addr  out  16  fetch address, equals pc_curr
- imem_req  out  1  fetch request
- pc_curr  out  16  current PC, to PC control
- halt_fetched  out  1  fetched word is HLT (opcode 4'hF), to PC control halt input
- fetch_busy  out  1  high in WAIT state (memory not ready)
- ifid_instr  out  16  registered instruction
- ifid_pc_plus2  out  16  registered PC+2 of that instruction
- ifid_valid  out  1  IF/ID holds a real instruction

## Operation
- States: RUN, WAIT, HALTED. Reset state is RUN.
- Definition: advance = (state != HALTED) & imem_ready & ~stall & ~branch_taken.
- Update priority is rst, then branch_taken, then stall, then advance, then bubble.
- branch_taken, any state:
  - pc <= pc_next
  - IF/ID <= {NOP_INSTR, valid 0}
  - state <= RUN
  - Any outstanding fetch is discarded.
- stall with no flush: pc, IF/ID and state all hold. A ready word is not consumed and is refetched next cycle.
- advance:
  - pc <= pc_next
  - ifid_instr <= imem_data, ifid_pc_plus2 <= pc+2, ifid_valid <= 1
  - If imem_data[15:12] == 4'hF, state <= HALTED; otherwise state <= RUN.
- RUN or WAIT with imem_ready low and no stall or flush:
  - state <= WAIT
  - pc holds
  - IF/ID <= bubble (NOP_INSTR, valid 0)
- HALTED:
  - imem_req = 0, and pc holds.
  - IF/ID receives bubbles unless stall is high.
  - Exit only via rst or branch_taken. This covers a HLT fetched on the wrong path.
- halt_fetched = (state != HALTED) & imem_ready & (imem_data[15:12] == 4'hF). It is combinational so that PC control holds the PC in the same cycle.
- imem_req = (state != HALTED). imem_addr = pc.
- PC+2 wraps modulo 2^16: 16'hFFFE + 2 = 16'h0000.

## Timing
- Reset values:
  - pc_curr = RESET_PC
  - ifid_instr = NOP_INSTR
  - ifid_pc_plus2 = 16'h0000
  - ifid_valid = 0
  - fetch_busy = 0
  - imem_req = 1 in the first cycle after reset
- Latency: a word accepted at edge N appears on the ifid_* outputs after edge N, one cycle later.
- Zero-wait memory gives one instruction per cycle.
- branch_taken at edge N means the instruction from pc_next is fetched in cycle N+1 and is visible in IF/ID after edge N+1.
- branch_taken with stall in the same cycle: the flush wins.
- rst asserted mid-WAIT or mid-HALTED returns to RUN at RESET_PC on the next edge.

## Configuration
- FETCH_PERF_CNT_EN defined: adds three 32-bit outputs, each cleared by rst and wrapping at 2^32:
  - perf_fetched, counts advance cycles
  - perf_wait_cycles, counts cycles in WAIT
  - perf_flushes, counts branch_taken cycles
- FETCH_PERF_CNT_EN undefined: these ports and counters do not exist. Fetch behaviour is identical either way.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants, including OPC_HLT = 4'hF
  - the NOP encoding
  - the reset vector
  - the fetch state enum {RUN, WAIT, HALTED}
- One sub-module, `ifid_reg`. It is the 33-bit IF/ID register with hold (stall), squash (flush or bubble) and load controls.
- PC+2 uses the existing 16-bit CLA adder.

## Test plan
- Reset, then imem_ready=1 and pc_next=pc+2 fed back: pc_curr steps 0000, 0002, 0004. ifid_pc_plus2 is 0002 one cycle after the first fetch.
- imem_ready low for 3 cycles at pc 0004:
  - fetch_busy is high for 3 cycles.
  - ifid_valid is 0 for 3 cycles.
  - pc stays 0004, then resumes.
- stall high for 2 cycles: pc and ifid_* are unchanged for 2 cycles, and there is no instruction loss or duplication afterward.
- branch_taken with pc_next=0x0040 during WAIT: pc is 0040 next cycle, ifid_valid=0, state is RUN.
- Fetch 16'hF000 at pc 0010:
  - halt_fetched=1 that cycle.
  - IF/ID holds F000 with valid 1.
  - imem_req=0 afterward.
  - A later branch_taken to 0x0020 resumes fetch at 0020.
- pc 16'hFFFE fetch: ifid_pc_plus2 is 16'h0000. rst during HALTED gives pc 0000 and imem_req 1.
